color_input_encoder: RTL and testbench

Upstream input stage for the Simon-Says game FSM. It takes the four raw player buttons and synchronises and debounces them. Each clean single-button press becomes a colour code on the same encoding the game FSM compares against its pattern (RED=0, GREEN=1, BLUE=2, YELLOW=3, NULL=4). The code is presented as a held colour plus a one-cycle valid strobe; between presses the output is NULL.

---
 rtl/color_input_encoder.sv | 128 ++++++++++++
 tb/tb_color_input_encoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/color_input_encoder.sv
// Button front end for the Simon-Says game: synchronises and debounces four raw buttons,
// then presents each clean single-button press as a colour code with a one-cycle strobe.
module color_input_encoder #(
  parameter int IN_BITS         = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 25000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       btn,
  output logic [IN_BITS:0] color,
  output logic             valid,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int MAX_CYC = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IN_BITS:0] COLOR_NULL = (IN_BITS + 1)'(4);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_DEBOUNCE     = 2'd1,
    S_HOLD         = 2'd2,
    S_WAIT_RELEASE = 2'd3
  } state_t;

  state_t           r_state;
  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_cand;
  logic [IN_BITS:0] r_color;
  logic             r_valid;

  logic             w_onehot;
  logic [1:0]       w_idx;
  logic [3:0]       w_cand_mask;

  // Output handshake: valid is a single-cycle strobe with no back-pressure; the consumer
  // must take color in the cycle valid is high. color stays non-NULL for the hold window.
  assign w_onehot    = (r_sync2 != 4'd0) && ((r_sync2 & (r_sync2 - 4'd1)) == 4'd0);
  assign w_cand_mask = 4'b0001 << r_cand;

  always_comb begin
    w_idx = 2'd0;
    case (r_sync2)
      4'b0001: w_idx = 2'd0;
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= 4'd0;
      r_sync2 <= 4'd0;
      r_cnt   <= '0;
      r_cand  <= 2'd0;
      r_color <= COLOR_NULL;
      r_valid <= 1'b0;
      r_state <= S_WAIT_RELEASE;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_color <= COLOR_NULL;
          if (w_onehot) begin
            r_cand  <= w_idx;
            r_cnt   <= '0;
            r_state <= S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (r_sync2 != w_cand_mask) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (r_cnt == DEB_LAST) begin
            r_color <= (IN_BITS + 1)'(r_cand);
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_HOLD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          // Buttons are deliberately ignored here; release is handled afterwards.
          if (r_cnt == HOLD_LAST) begin
            r_color <= COLOR_NULL;
            r_cnt   <= '0;
            r_state <= S_WAIT_RELEASE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_RELEASE: begin
          r_color <= COLOR_NULL;
          if (r_sync2 != 4'd0) begin
            r_cnt <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_color <= COLOR_NULL;
          r_cnt   <= '0;
          r_state <= S_WAIT_RELEASE;
        end
      endcase
    end
  end

  assign color     = r_color;
  assign valid     = r_valid;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_color_input_encoder.sv
// Bench for color_input_encoder: directed scenarios plus random button traffic, checked
// cycle by cycle against a press/hold/release reference model and a colour scoreboard.
module tb_color_input_encoder;

  localparam int D = 4;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] btn = 4'd0;
  logic [2:0] color;
  logic       valid;
  logic       busy;
  logic [1:0] dbg_state;

  color_input_encoder #(
    .IN_BITS(2),
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn(btn),
    .color(color),
    .valid(valid),
    .busy(busy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int dut_valids = 0;
  int valid_mark = 0;

  logic [2:0] exp_q[$];

  // reference model: presentation window, release quiet count, press streak
  logic [3:0] m_sync1 = 4'd0;
  logic [3:0] m_s = 4'd0;
  logic [3:0] m_cand = 4'd0;
  logic       m_armed = 1'b0;
  logic       m_fire = 1'b0;
  int         m_present = 0;
  int         m_quiet = 0;
  int         m_streak = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] btn_colour(input logic [3:0] v);
    logic [2:0] r;
    r = 3'd4;
    for (int i = 0; i < 4; i++) if (v == (4'd1 << i)) r = 3'(i);
    return r;
  endfunction

  task automatic model_edge();
    logic [3:0] s;
    if (!reset) begin
      m_sync1 = 4'd0; m_s = 4'd0;
      m_present = 0; m_quiet = 0; m_streak = 0;
      m_armed = 1'b0; m_fire = 1'b0;
      return;
    end
    s = m_s;
    m_s = m_sync1;
    m_sync1 = btn;
    m_fire = 1'b0;
    if (m_present > 0) begin
      m_present--;
      if (m_present == 0) begin
        m_armed = 1'b0;
        m_quiet = 0;
      end
    end else if (!m_armed) begin
      if (s != 4'd0) m_quiet = 0;
      else begin
        m_quiet++;
        if (m_quiet == D) begin
          m_armed = 1'b1;
          m_streak = 0;
        end
      end
    end else if (m_streak == 0) begin
      if ($countones(s) == 1) begin
        m_cand = s;
        m_streak = 1;
      end
    end else if (s == m_cand) begin
      m_streak++;
      if (m_streak == D + 1) begin
        m_fire = 1'b1;
        m_present = H;
        m_streak = 0;
        exp_q.push_back(btn_colour(m_cand));
      end
    end else begin
      m_streak = 0;
    end
  endtask

  // one clock: model follows the edge, outputs checked on the falling edge
  task automatic step();
    logic [2:0] exp_color;
    logic       exp_busy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    exp_color = (m_present > 0) ? btn_colour(m_cand) : 3'd4;
    exp_busy  = !(m_armed && m_present == 0 && m_streak == 0);
    check_eq("color", 32'(color), 32'(exp_color));
    check_eq("valid", 32'(valid), 32'(m_fire));
    check_eq("busy", 32'(busy), 32'(exp_busy));
    if (valid === 1'b1) begin
      dut_valids++;
      if (exp_q.size() == 0) check_eq("sb_unexpected_valid", 32'(1), 32'(0));
      else check_eq("sb_color", 32'(color), 32'(exp_q.pop_front()));
    end
  endtask

  // driver tasks
  task automatic hold_btn(input logic [3:0] b, input int n);
    btn = b;
    repeat (n) step();
  endtask

  task automatic pulse_reset(input int n);
    reset = 1'b0;
    repeat (n) step();
    reset = 1'b1;
  endtask

  task automatic expect_presses(input string tag, input int n);
    check_eq(tag, 32'(dut_valids - valid_mark), 32'(n));
    valid_mark = dut_valids;
  endtask

  initial begin
    logic [3:0] b;
    int         r;

    // 1: power-up reset, then release wait into idle
    pulse_reset(3);
    hold_btn(4'd0, 10);
    check_eq("idle_after_reset", 32'(busy), 32'(0));
    expect_presses("t1_presses", 0);

    // 2: single green press held long
    hold_btn(4'b0010, 30);
    hold_btn(4'd0, 10);
    expect_presses("t2_presses", 1);

    // 3: bouncing blue, then bouncing followed by a stable press
    repeat (5) begin hold_btn(4'b0100, 2); hold_btn(4'd0, 2); end
    hold_btn(4'd0, 6);
    expect_presses("t3_bounce_presses", 0);
    repeat (5) begin hold_btn(4'b0100, 2); hold_btn(4'd0, 2); end
    hold_btn(4'b0100, 20);
    hold_btn(4'd0, 10);
    expect_presses("t3_stable_presses", 1);

    // 4: simultaneous red+blue ignored, then red alone
    hold_btn(4'b0101, 20);
    hold_btn(4'd0, 10);
    expect_presses("t4_multi_presses", 0);
    hold_btn(4'b0001, 20);
    hold_btn(4'd0, 10);
    expect_presses("t4_red_presses", 1);

    // 5: yellow press, red added during the hold
    hold_btn(4'b1000, 9);
    hold_btn(4'b1001, 10);
    hold_btn(4'b1000, 5);
    hold_btn(4'd0, 10);
    expect_presses("t5_presses", 1);

    // 6: reset in the middle of a hold while green stays pressed
    hold_btn(4'b0010, 10);
    pulse_reset(1);
    check_eq("t6_color_after_reset", 32'(color), 32'(4));
    hold_btn(4'b0010, 15);
    expect_presses("t6_first_press", 1);
    hold_btn(4'd0, 10);
    hold_btn(4'b0010, 20);
    hold_btn(4'd0, 10);
    expect_presses("t6_fresh_press", 1);

    // random button traffic with occasional resets
    for (int seg = 0; seg < 300; seg++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) b = 4'd0;
      else if (r <= 7) b = 4'd1 << $urandom_range(0, 3);
      else b = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) pulse_reset($urandom_range(1, 3));
      hold_btn(b, $urandom_range(1, 12));
    end
    hold_btn(4'd0, 20);

    check_eq("sb_drain", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
